// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the cache read arbiter: request type encodings, AXI
// constants, default read ids, FSM state type and the latched AR payload.
package axi_rd_arbiter_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ID_W     = 4;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned LINE_OFS = 4;   // 16-byte cache line

    localparam logic [2:0] RD_TYPE_BYTE = 3'b000;
    localparam logic [2:0] RD_TYPE_HALF = 3'b001;
    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int unsigned ID_I_DEFAULT = 0;
    localparam int unsigned ID_D_DEFAULT = 1;

    typedef enum logic {
        AR_IDLE,
        AR_SEND
    } ar_state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [2:0]        size;
    } ar_req_t;

    // True when both addresses fall in the same cache line.
    function automatic logic line_hit(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return ((a ^ b) >> LINE_OFS) == '0;
    endfunction

endpackage

// File: rtl/axi_rd_arbiter_prio.sv
// Eligibility and priority select between ICache and DCache read requests.
// Ports:
//   en_i           grant window open (AR channel idle, out of reset)
//   starve_full_i  ICache has waited through the starvation limit
//   ic_*/dc_*      request, address and outstanding flag per cache
//   wr_pending_i   a write is in flight to wr_addr_i
//   grant_*_c_o    combinational one-hot grant
module axi_rd_arbiter_prio
    import axi_rd_arbiter_pkg::*;
(
    input  logic              en_i,
    input  logic              starve_full_i,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    input  logic              ic_busy_i,
    input  logic              dc_req_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic              dc_busy_i,
    input  logic              wr_pending_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    output logic              grant_ic_c_o,
    output logic              grant_dc_c_o
);

    logic ic_elig;
    logic dc_elig;

    // A read to a line with a write still in flight must wait for the B response.
    assign ic_elig = ic_req_i & ~ic_busy_i & ~(wr_pending_i & line_hit(wr_addr_i, ic_addr_i));
    assign dc_elig = dc_req_i & ~dc_busy_i & ~(wr_pending_i & line_hit(wr_addr_i, dc_addr_i));

    // DCache wins by default; a starved ICache is served first.
    always_comb begin
        grant_ic_c_o = 1'b0;
        grant_dc_c_o = 1'b0;
        if (en_i) begin
            if (starve_full_i && ic_elig) begin
                grant_ic_c_o = 1'b1;
            end else if (dc_elig) begin
                grant_dc_c_o = 1'b1;
            end else if (ic_elig) begin
                grant_ic_c_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates ICache/DCache reads onto one AXI AR/R channel pair, one outstanding
// read per cache tagged by ARID, and steers R beats back by RID.
// Ports:
//   aclk, aresetn            clock, synchronous active-low reset
//   ic_rd_*/dc_rd_*          cache request (req/type/addr in, rdy out)
//   ic_ret_*/dc_ret_*        combinational return beat to each cache
//   wr_pending, wr_addr      in-flight write used for read-after-write hazard
//   ar*/r*                   AXI read address and data channels
//   rd_err                   sticky error: bad rresp or unknown rid
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int unsigned ID_I         = ID_I_DEFAULT,
    parameter int unsigned ID_D         = ID_D_DEFAULT,
    parameter int unsigned LINE_BEATS   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ic_rd_req,
    input  logic [2:0]  ic_rd_type,
    input  logic [31:0] ic_rd_addr,
    output logic        ic_rd_rdy,
    output logic        ic_ret_valid,
    output logic        ic_ret_last,
    output logic [31:0] ic_ret_data,
    input  logic        dc_rd_req,
    input  logic [2:0]  dc_rd_type,
    input  logic [31:0] dc_rd_addr,
    output logic        dc_rd_rdy,
    output logic        dc_ret_valid,
    output logic        dc_ret_last,
    output logic [31:0] dc_ret_data,
    input  logic        wr_pending,
    input  logic [31:0] wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic        rd_err
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    ar_state_e     state_q, state_d;
    ar_req_t       ar_q, ar_d;
    logic          busy_i_q, busy_i_d;
    logic          busy_d_q, busy_d_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          rd_err_q, rd_err_d;

    logic grant_ic, grant_dc;
    logic hs_ic, hs_dc;
    logic beat_ok, rid_ic, rid_dc;

    // Build the AR payload for a cache request.
    function automatic ar_req_t build_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                                         input logic [2:0] typ);
        ar_req_t r;
        r.id   = id;
        r.addr = addr;
        r.len  = (typ == RD_TYPE_LINE) ? LEN_W'(LINE_BEATS - 1) : '0;
        r.size = (typ == RD_TYPE_LINE) ? 3'b010 : {1'b0, typ[1:0]};
        return r;
    endfunction

    axi_rd_arbiter_prio u_prio (
        .en_i          (aresetn && (state_q == AR_IDLE)),
        .starve_full_i (starve_q == SW'(STARVE_LIMIT)),
        .ic_req_i      (ic_rd_req),
        .ic_addr_i     (ic_rd_addr),
        .ic_busy_i     (busy_i_q),
        .dc_req_i      (dc_rd_req),
        .dc_addr_i     (dc_rd_addr),
        .dc_busy_i     (busy_d_q),
        .wr_pending_i  (wr_pending),
        .wr_addr_i     (wr_addr),
        .grant_ic_c_o  (grant_ic),
        .grant_dc_c_o  (grant_dc)
    );

    assign ic_rd_rdy = grant_ic;
    assign dc_rd_rdy = grant_dc;
    assign hs_ic     = ic_rd_req & grant_ic;
    assign hs_dc     = dc_rd_req & grant_dc;

    // R channel: accept while any read is outstanding, steer by id with no latency.
    assign rready       = busy_i_q | busy_d_q;
    assign beat_ok      = rvalid & rready;
    assign rid_ic       = (rid == ID_W'(ID_I));
    assign rid_dc       = (rid == ID_W'(ID_D));
    assign ic_ret_valid = beat_ok & rid_ic;
    assign ic_ret_last  = rlast;
    assign ic_ret_data  = rdata;
    assign dc_ret_valid = beat_ok & rid_dc;
    assign dc_ret_last  = rlast;
    assign dc_ret_data  = rdata;

    assign arvalid = (state_q == AR_SEND);
    assign arid    = ar_q.id;
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign rd_err  = rd_err_q;

    // AR FSM next state and payload latch.
    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        case (state_q)
            AR_IDLE: begin
                if (hs_ic) begin
                    state_d = AR_SEND;
                    ar_d    = build_ar(ID_W'(ID_I), ic_rd_addr, ic_rd_type);
                end else if (hs_dc) begin
                    state_d = AR_SEND;
                    ar_d    = build_ar(ID_W'(ID_D), dc_rd_addr, dc_rd_type);
                end
            end
            AR_SEND: begin
                if (arready) begin
                    state_d = AR_IDLE;
                end
            end
            default: state_d = AR_IDLE;
        endcase
    end

    // Outstanding flags, starvation count and sticky error.
    always_comb begin
        busy_i_d = busy_i_q;
        busy_d_d = busy_d_q;
        starve_d = starve_q;
        rd_err_d = rd_err_q;
        // Clear on last beat before set, so a stray last beat cannot drop a fresh grant.
        if (beat_ok && rlast && rid_ic) busy_i_d = 1'b0;
        if (beat_ok && rlast && rid_dc) busy_d_d = 1'b0;
        if (hs_ic) busy_i_d = 1'b1;
        if (hs_dc) busy_d_d = 1'b1;
        if (hs_ic) begin
            starve_d = '0;
        end else if (hs_dc && ic_rd_req && (starve_q != SW'(STARVE_LIMIT))) begin
            starve_d = starve_q + SW'(1);
        end
        if (beat_ok && ((rresp != 2'b00) || !(rid_ic || rid_dc))) rd_err_d = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= AR_IDLE;
            ar_q     <= '0;
            busy_i_q <= 1'b0;
            busy_d_q <= 1'b0;
            starve_q <= '0;
            rd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ar_q     <= ar_d;
            busy_i_q <= busy_i_d;
            busy_d_q <= busy_d_d;
            starve_q <= starve_d;
            rd_err_q <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: expected AR requests and return beats
// are queued as stimulus is driven and compared when the DUT presents them.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        ic_rd_req, dc_rd_req;
    logic [2:0]  ic_rd_type, dc_rd_type;
    logic [31:0] ic_rd_addr, dc_rd_addr;
    logic        ic_rd_rdy, dc_rd_rdy;
    logic        ic_ret_valid, ic_ret_last, dc_ret_valid, dc_ret_last;
    logic [31:0] ic_ret_data, dc_ret_data;
    logic        wr_pending;
    logic [31:0] wr_addr;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready, rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    ar_req_t     exp_ar[$];
    logic [32:0] exp_ic[$];
    logic [32:0] exp_dc[$];

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
        .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
        .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
        .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
        .wr_pending(wr_pending), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic ar_req_t mk_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] typ);
        ar_req_t r;
        r.id   = id;
        r.addr = addr;
        r.len  = (typ == RD_TYPE_LINE) ? 8'd3 : 8'd0;
        r.size = (typ == RD_TYPE_LINE) ? 3'd2 : {1'b0, typ[1:0]};
        return r;
    endfunction

    // Drive one R beat for the current cycle; queue the expected return if the id is known.
    task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                             input logic last);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        rresp  = resp;
        rlast  = last;
        if (id == 4'd0) exp_ic.push_back({last, d});
        else if (id == 4'd1) exp_dc.push_back({last, d});
    endtask

    // Monitor: AR payload while valid (stable until accepted) and steered return beats.
    always @(negedge aclk) begin
        if (aresetn === 1'b1 && arvalid) begin
            if (exp_ar.size() == 0) begin
                check("ar_unexpected", 64'(1), 64'(0));
            end else begin
                check(arready ? "ar_issue" : "ar_hold", 64'({arid, araddr, arlen, arsize}), 64'(exp_ar[0]));
                if (arready) void'(exp_ar.pop_front());
            end
        end
        if (ic_ret_valid === 1'b1) begin
            if (exp_ic.size() == 0) check("ic_ret_unexpected", 64'(1), 64'(0));
            else check("ic_ret", 64'({ic_ret_last, ic_ret_data}), 64'(exp_ic.pop_front()));
        end
        if (dc_ret_valid === 1'b1) begin
            if (exp_dc.size() == 0) check("dc_ret_unexpected", 64'(1), 64'(0));
            else check("dc_ret", 64'({dc_ret_last, dc_ret_data}), 64'(exp_dc.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dca [5];
        logic [2:0]  dct [5];
        logic [3:0]  il_id [8];

        aresetn = 1'b0;
        ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_WORD; ic_rd_addr = 32'h0;
        dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_WORD; dc_rd_addr = 32'h4;
        wr_pending = 1'b0; wr_addr = 32'h0;
        arready = 1'b0;
        rvalid = 1'b0; rid = 4'd0; rdata = 32'h0; rresp = 2'b00; rlast = 1'b0;

        // Reset held with requests asserted.
        repeat (2) begin
            @(negedge aclk);
            check("rst_arvalid", 64'(arvalid), 64'(0));
            check("rst_ic_rdy", 64'(ic_rd_rdy), 64'(0));
            check("rst_dc_rdy", 64'(dc_rd_rdy), 64'(0));
            check("rst_rready", 64'(rready), 64'(0));
            check("rst_rd_err", 64'(rd_err), 64'(0));
        end
        tick();
        aresetn = 1'b1; ic_rd_req = 1'b0; dc_rd_req = 1'b0;
        tick();

        // ICache line read, arready three cycles late.
        ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_LINE; ic_rd_addr = 32'h1c00_0010;
        @(negedge aclk);
        check("s1_ic_rdy", 64'(ic_rd_rdy), 64'(1));
        check("s1_dc_rdy", 64'(dc_rd_rdy), 64'(0));
        exp_ar.push_back(mk_ar(4'd0, 32'h1c00_0010, RD_TYPE_LINE));
        tick();
        ic_rd_req = 1'b0;
        repeat (3) begin
            @(negedge aclk);
            check("s1_arvalid_wait", 64'(arvalid), 64'(1));
            check("s1_ic_rdy_send", 64'(ic_rd_rdy), 64'(0));
            tick();
        end
        arready = 1'b1;
        @(negedge aclk);
        tick();
        arready = 1'b0;
        @(negedge aclk);
        check("s1_arvalid_done", 64'(arvalid), 64'(0));
        check("s1_rready", 64'(rready), 64'(1));
        tick();
        for (int k = 0; k < 4; k++) begin
            send_beat(4'd0, 32'hA000_0000 + 32'(k), 2'b00, k == 3);
            @(negedge aclk);
            tick();
        end
        rvalid = 1'b0;
        @(negedge aclk);
        check("s1_rready_idle", 64'(rready), 64'(0));
        tick();

        // Simultaneous requests: DCache first, ICache on the next idle cycle.
        ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_LINE; ic_rd_addr = 32'h0000_0100;
        dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_LINE; dc_rd_addr = 32'h0000_2000;
        @(negedge aclk);
        check("s2_dc_rdy", 64'(dc_rd_rdy), 64'(1));
        check("s2_ic_rdy", 64'(ic_rd_rdy), 64'(0));
        exp_ar.push_back(mk_ar(4'd1, 32'h0000_2000, RD_TYPE_LINE));
        tick();
        dc_rd_req = 1'b0; arready = 1'b1;
        @(negedge aclk);
        check("s2_ic_rdy_send", 64'(ic_rd_rdy), 64'(0));
        tick();
        @(negedge aclk);
        check("s2_ic_rdy_next", 64'(ic_rd_rdy), 64'(1));
        exp_ar.push_back(mk_ar(4'd0, 32'h0000_0100, RD_TYPE_LINE));
        tick();
        ic_rd_req = 1'b0;
        @(negedge aclk);
        tick();
        arready = 1'b0;
        @(negedge aclk);
        check("s2_rready_both", 64'(rready), 64'(1));
        check("s2_rd_err_clean", 64'(rd_err), 64'(0));
        tick();

        // Interleaved beats; an error response on the second beat.
        il_id = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0};
        for (int k = 0; k < 8; k++) begin
            send_beat(il_id[k], (il_id[k] == 4'd1 ? 32'hD000_0000 : 32'h1C00_0000) + 32'(k / 2),
                      (k == 1) ? 2'b10 : 2'b00, k >= 6);
            @(negedge aclk);
            tick();
            check("s2_rd_err", 64'(rd_err), 64'(k >= 1));
        end
        rvalid = 1'b0;
        @(negedge aclk);
        check("s2_rready_idle", 64'(rready), 64'(0));
        check("s2_rd_err_sticky", 64'(rd_err), 64'(1));
        tick();

        // Fresh reset, then starve the ICache behind a write hazard.
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("st_rd_err_reset", 64'(rd_err), 64'(0));
        dca = '{32'h4000_0000, 32'h4000_0010, 32'h4000_0020, 32'h4000_0030, 32'h4000_0040};
        dct = '{RD_TYPE_WORD, RD_TYPE_HALF, RD_TYPE_BYTE, RD_TYPE_WORD, RD_TYPE_WORD};
        wr_pending = 1'b1; wr_addr = 32'h3000_0000;
        ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_WORD; ic_rd_addr = 32'h3000_0008;
        dc_rd_req = 1'b1; dc_rd_type = dct[0]; dc_rd_addr = dca[0];
        for (int g = 0; g < 4; g++) begin
            @(negedge aclk);
            check("st_dc_rdy", 64'(dc_rd_rdy), 64'(1));
            check("st_ic_rdy", 64'(ic_rd_rdy), 64'(0));
            exp_ar.push_back(mk_ar(4'd1, dca[g], dct[g]));
            tick();
            dc_rd_req = 1'b0; arready = 1'b1;
            @(negedge aclk);
            tick();
            arready = 1'b0;
            if (g == 3) begin
                check("st_rd_err_pre", 64'(rd_err), 64'(0));
                send_beat(4'd7, 32'hDEAD_BEEF, 2'b00, 1'b1);
                @(negedge aclk);
                tick();
                check("st_rd_err_unknown_rid", 64'(rd_err), 64'(1));
            end
            dc_rd_req = 1'b1; dc_rd_type = dct[g+1]; dc_rd_addr = dca[g+1];
            send_beat(4'd1, 32'hD0 + 32'(g), 2'b00, 1'b1);
            @(negedge aclk);
            check("st_dc_blocked_busy", 64'(dc_rd_rdy), 64'(0));
            check("st_ic_blocked_hazard", 64'(ic_rd_rdy), 64'(0));
            tick();
            rvalid = 1'b0;
            if (g == 3) wr_pending = 1'b0;
        end
        @(negedge aclk);
        check("st_ic_forced", 64'(ic_rd_rdy), 64'(1));
        check("st_dc_yield", 64'(dc_rd_rdy), 64'(0));
        exp_ar.push_back(mk_ar(4'd0, 32'h3000_0008, RD_TYPE_WORD));
        tick();
        ic_rd_req = 1'b0; arready = 1'b1;
        @(negedge aclk);
        tick();
        @(negedge aclk);
        check("st_dc_after", 64'(dc_rd_rdy), 64'(1));
        exp_ar.push_back(mk_ar(4'd1, dca[4], dct[4]));
        tick();
        dc_rd_req = 1'b0;
        @(negedge aclk);
        tick();
        arready = 1'b0;
        send_beat(4'd0, 32'h1111_0000, 2'b00, 1'b1);
        @(negedge aclk);
        tick();
        send_beat(4'd1, 32'h2222_0000, 2'b00, 1'b1);
        @(negedge aclk);
        tick();
        rvalid = 1'b0;
        // Starvation count restarted by the ICache grant: DCache wins a tie again.
        ic_rd_req = 1'b1; dc_rd_req = 1'b1; dc_rd_addr = 32'h4000_0050; dc_rd_type = RD_TYPE_WORD;
        @(negedge aclk);
        check("st_dc_wins_after_clear", 64'(dc_rd_rdy), 64'(1));
        check("st_ic_waits_after_clear", 64'(ic_rd_rdy), 64'(0));
        exp_ar.push_back(mk_ar(4'd1, 32'h4000_0050, RD_TYPE_WORD));
        tick();
        ic_rd_req = 1'b0; dc_rd_req = 1'b0; arready = 1'b1;
        @(negedge aclk);
        tick();
        arready = 1'b0;
        send_beat(4'd1, 32'h3333_0000, 2'b00, 1'b1);
        @(negedge aclk);
        tick();
        rvalid = 1'b0;

        // Write hazard on the DCache line.
        wr_pending = 1'b1; wr_addr = 32'h0000_0800;
        dc_rd_req = 1'b1; dc_rd_type = RD_TYPE_BYTE; dc_rd_addr = 32'h0000_080c;
        repeat (3) begin
            @(negedge aclk);
            check("wh_dc_stalled", 64'(dc_rd_rdy), 64'(0));
            tick();
        end
        wr_pending = 1'b0;
        @(negedge aclk);
        check("wh_dc_released", 64'(dc_rd_rdy), 64'(1));
        exp_ar.push_back(mk_ar(4'd1, 32'h0000_080c, RD_TYPE_BYTE));
        tick();
        dc_rd_req = 1'b0; arready = 1'b1;
        @(negedge aclk);
        tick();
        arready = 1'b0;
        send_beat(4'd1, 32'h0000_0055, 2'b00, 1'b1);
        @(negedge aclk);
        tick();
        rvalid = 1'b0;

        // Reset in the middle of a burst; stale beats afterwards are not accepted.
        ic_rd_req = 1'b1; ic_rd_type = RD_TYPE_LINE; ic_rd_addr = 32'h0000_0500;
        @(negedge aclk);
        check("rm_ic_rdy", 64'(ic_rd_rdy), 64'(1));
        exp_ar.push_back(mk_ar(4'd0, 32'h0000_0500, RD_TYPE_LINE));
        tick();
        ic_rd_req = 1'b0; arready = 1'b1;
        @(negedge aclk);
        tick();
        arready = 1'b0;
        send_beat(4'd0, 32'h0000_0077, 2'b00, 1'b0);
        @(negedge aclk);
        tick();
        rvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h0000_0078; rresp = 2'b00; rlast = 1'b0;
        @(negedge aclk);
        check("rm_rready", 64'(rready), 64'(0));
        check("rm_ic_ret_valid", 64'(ic_ret_valid), 64'(0));
        check("rm_arvalid", 64'(arvalid), 64'(0));
        tick();
        rvalid = 1'b0;

        check("ar_consts", 64'({arburst, arlock, arcache, arprot}), 64'({2'b01, 2'b00, 4'b0000, 3'b000}));
        check("ar_queue_empty", 64'(exp_ar.size()), 64'(0));
        check("ic_queue_empty", 64'(exp_ic.size()), 64'(0));
        check("dc_queue_empty", 64'(exp_dc.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
